// File: rtl/seq_rca_adder.sv
`default_nettype none
// ============================================================================
//  Module      : seq_rca_adder
//  Description : Multi-cycle ripple-carry adder/subtractor. The block adds one
//                CHUNK-bit slice per clock, LSB slice first. The result, carry-out
//                and signed overflow are published together when the last
//                slice is done. A one-cycle done pulse marks each new result.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_rca_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    // Number of slices and the width of the slice index
    localparam int c_N     = WIDTH / CHUNK;
    localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_N - 1);

    // FSM encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;

    // Operands captured at the accepting edge. B is stored already inverted
    // for subtraction, and the initial carry already holds the +1. That way
    // the RUN datapath is the same for add and subtract.
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [c_IDX_W-1:0] r_idx;
    logic [WIDTH-1:0]   r_acc;

    // Published result registers
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    // Slice datapath
    logic [CHUNK-1:0]   w_a_slice;
    logic [CHUNK-1:0]   w_b_slice;
    logic [CHUNK:0]     w_slice_sum;
    logic [WIDTH-1:0]   w_acc_next;
    logic               w_last;
    logic               w_ovf;

    // Select the current slice, add it, and merge the slice result into the accumulator
    always_comb begin
        w_a_slice   = r_a[int'(r_idx) * CHUNK +: CHUNK];
        w_b_slice   = r_b[int'(r_idx) * CHUNK +: CHUNK];
        w_slice_sum = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{CHUNK{1'b0}}, r_carry};
        w_acc_next  = r_acc;
        w_acc_next[int'(r_idx) * CHUNK +: CHUNK] = w_slice_sum[CHUNK-1:0];
        w_last      = (r_idx == c_LAST_IDX);
        // Signed overflow: the effective operands agree in sign, but the result does not
        w_ovf       = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                      (w_acc_next[WIDTH-1] != r_a[WIDTH-1]);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. start is honoured only in IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (start)  w_state_next = c_ST_RUN;
            c_ST_RUN:  if (w_last) w_state_next = c_ST_DONE;
            c_ST_DONE: w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    // Operand capture, slice-by-slice accumulation and result publication
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B ^ {WIDTH{sub}};
                        r_carry <= sub ? 1'b1 : Cin;
                        r_idx   <= '0;
                    end
                end
                c_ST_RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_slice_sum[CHUNK];
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_sum  <= w_acc_next;
                        r_cout <= w_slice_sum[CHUNK];
                        r_ovf  <= w_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;
    assign busy = (r_state != c_ST_IDLE);
    assign done = (r_state == c_ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_rca_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_rca_adder
//  Description : Self-checking bench for seq_rca_adder. It uses a 16/4 instance
//                and a legacy 4/4 instance, checked against an arithmetic
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_rca_adder;

    localparam int c_N16 = 4;
    localparam int c_N4  = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start16 = 1'b0, sub16 = 1'b0, cin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [15:0] sum16;
    logic        cout16, ovf16, busy16, done16;

    logic        start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [3:0]  sum4;
    logic        cout4, ovf4, busy4, done4;

    int          n_checks = 0;
    int          n_errors = 0;

    logic [15:0] prev_sum  = '0;
    logic        prev_cout = 1'b0;
    logic        prev_ovf  = 1'b0;

    seq_rca_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .A(a16), .B(b16), .Cin(cin16),
        .sum(sum16), .cout(cout16), .ovf(ovf16), .busy(busy16), .done(done16)
    );

    seq_rca_adder #(.WIDTH(4), .CHUNK(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub4), .A(a4), .B(b4), .Cin(cin4),
        .sum(sum4), .cout(cout4), .ovf(ovf4), .busy(busy4), .done(done4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands
    function automatic void model(input int w, input longint a, input longint b,
                                  input bit cin, input bit s,
                                  output longint r, output bit co, output bit ov);
        longint m, sa, sb, u, sr;
        m  = longint'(1) << w;
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        if (s) begin
            u  = a - b;
            co = (a >= b);
            sr = sa - sb;
        end else begin
            u  = a + b + longint'(cin);
            co = (u >= m);
            sr = sa + sb + longint'(cin);
        end
        r  = ((u % m) + m) % m;
        ov = (sr >= m / 2) || (sr < -(m / 2));
    endfunction

    // One operation on the 16-bit instance; optionally disturb inputs/start during RUN
    task automatic do_op16(input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic s, input bit scramble);
        longint es;
        bit     eco, eov, got;
        int     cycles;
        model(16, longint'(a), longint'(b), cin, s, es, eco, eov);
        @(negedge clk);
        a16 = a; b16 = b; cin16 = cin; sub16 = s; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles <= 3 * c_N16 + 4) begin
            if (scramble) begin
                a16 = 16'($urandom); b16 = 16'($urandom);
                cin16 = 1'($urandom); sub16 = 1'($urandom); start16 = 1'($urandom);
            end
            @(negedge clk);
            if (done16) begin
                got = 1'b1;
                start16 = 1'b0;
            end else begin
                check("busy_run",   32'(busy16), 32'(1));
                check("hold_sum",   32'(sum16),  32'(prev_sum));
                check("hold_flags", 32'({cout16, ovf16}), 32'({prev_cout, prev_ovf}));
                @(posedge clk); #1;
                cycles++;
            end
        end
        if (!got) begin
            check("done_timeout", 32'(0), 32'(1));
        end else begin
            check("latency",   32'(cycles), 32'(c_N16));
            check("sum",       32'(sum16),  32'(es));
            check("cout",      32'(cout16), 32'(eco));
            check("ovf",       32'(ovf16),  32'(eov));
            check("busy_done", 32'(busy16), 32'(1));
            @(negedge clk);
            check("done_pulse", 32'(done16), 32'(0));
            check("busy_idle",  32'(busy16), 32'(0));
        end
        prev_sum  = 16'(es);
        prev_cout = eco;
        prev_ovf  = eov;
    endtask

    // One operation on the legacy 4-bit instance
    task automatic do_op4(input logic [3:0] a, input logic [3:0] b,
                          input logic cin, input logic s);
        longint es;
        bit     eco, eov, got;
        int     cycles;
        model(4, longint'(a), longint'(b), cin, s, es, eco, eov);
        @(negedge clk);
        a4 = a; b4 = b; cin4 = cin; sub4 = s; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles <= 8) begin
            @(negedge clk);
            if (done4) got = 1'b1;
            else begin
                @(posedge clk); #1;
                cycles++;
            end
        end
        if (!got) begin
            check("done4_timeout", 32'(0), 32'(1));
        end else begin
            check("latency4", 32'(cycles), 32'(c_N4));
            check("sum4",     32'(sum4),   32'(es));
            check("cout4",    32'(cout4),  32'(eco));
            check("ovf4",     32'(ovf4),   32'(eov));
            @(negedge clk);
            check("done4_pulse", 32'(done4), 32'(0));
        end
    endtask

    // Reset during RUN: abort with no done pulse and cleared outputs
    task automatic abort_op16();
        @(negedge clk);
        a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b0; sub16 = 1'b0; start16 = 1'b1;
        @(posedge clk); #1;              // edge E
        start16 = 1'b0;
        @(posedge clk); #1;              // edge E+1
        rst = 1'b1;
        @(posedge clk); #1;              // edge E+2 applies reset
        @(negedge clk);
        check("abort_done",  32'(done16), 32'(0));
        check("abort_busy",  32'(busy16), 32'(0));
        check("abort_sum",   32'(sum16),  32'(0));
        check("abort_flags", 32'({cout16, ovf16}), 32'(0));
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done16), 32'(0));
        end
        prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_sum",   32'(sum16),  32'(0));
        check("rst_cout",  32'(cout16), 32'(0));
        check("rst_ovf",   32'(ovf16),  32'(0));
        check("rst_busy",  32'(busy16), 32'(0));
        check("rst_done",  32'(done16), 32'(0));
        check("rst_sum4",  32'(sum4),   32'(0));
        check("rst_busy4", 32'(busy4),  32'(0));
        rst = 1'b0;

        do_op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);   // add wrap
        do_op16(16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b0);   // overflow via Cin
        do_op16(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);   // subtract with borrow
        do_op16(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);   // subtract overflow
        do_op16(16'h1234, 16'h0F0F, 1'b0, 1'b0, 1'b1);   // inputs disturbed during RUN
        abort_op16();

        for (int i = 0; i < 24; i++) begin
            do_op16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                    bit'($urandom_range(0, 1)));
        end

        do_op4(4'b1110, 4'b1110, 1'b1, 1'b0);
        do_op4(4'b1001, 4'b1101, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            do_op4(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
